// File: rtl/cakegame_seq_recorder_pkg.sv
// cakegame_seq_recorder_pkg: shared widths, FSM state encoding and one-hot helper for the sequence recorder
package cakegame_seq_recorder_pkg;
  localparam int WIDTH = 7;
  localparam int ADDR_W = 4;
  localparam int DEPTH = 16;
  typedef enum logic [2:0] {IDLE, WAIT_PRESS, WAIT_RELEASE, WRITE, DONE} state_t;
  function automatic logic one_hot(input logic [WIDTH-1:0] v);
    return v != '0 && (v & (v - {{(WIDTH-1){1'b0}}, 1'b1})) == '0;
  endfunction
endpackage

// File: rtl/cakegame_seq_recorder_if.sv
// cakegame_seq_recorder_if: control/button inputs and RAM write port plus status of the sequence recorder
// master drives start/stop/buttons and observes the rest; slave is the recorder itself.
interface cakegame_seq_recorder_if;
  import cakegame_seq_recorder_pkg::*;
  logic start;
  logic stop;
  logic [WIDTH-1:0] buttons;
  logic wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0] wr_data;
  logic [ADDR_W:0] length;
  logic recording;
  logic done;
  logic timeout;
  logic error;
  modport master(output start, stop, buttons, input wr_en, wr_addr, wr_data, length, recording, done, timeout, error);
  modport slave(input start, stop, buttons, output wr_en, wr_addr, wr_data, length, recording, done, timeout, error);
endinterface

// File: rtl/cakegame_seq_recorder_debouncer.sv
// cakegame_seq_recorder_debouncer: stabilises raw buttons; pass-through unless CAKEGAME_DEBOUNCE_EN is defined
// Ports: clk, rst (async, active-high), raw (button inputs), stable (debounced vector).
module cakegame_seq_recorder_debouncer
  import cakegame_seq_recorder_pkg::*;
#(
  parameter int DEBOUNCE = 10
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] stable
);
`ifdef CAKEGAME_DEBOUNCE_EN
  localparam int CW = $clog2(DEBOUNCE + 1);
  logic [WIDTH-1:0] last;
  logic [CW-1:0] cnt;
  // any change restarts the window, so glitches shorter than DEBOUNCE never reach stable
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= '0;
      cnt <= '0;
      stable <= '0;
    end else if (raw != last) begin
      last <= raw;
      cnt <= '0;
    end else if (cnt != CW'(DEBOUNCE - 1)) begin
      cnt <= cnt + CW'(1);
    end else begin
      stable <= last;
    end
  end
`else
  logic unused_cfg;
  assign unused_cfg = clk ^ rst ^ (DEBOUNCE > 0);
  assign stable = raw;
`endif
endmodule

// File: rtl/cakegame_seq_recorder.sv
// cakegame_seq_recorder: records one-hot button plays into a 16x7 sync RAM for custom levels
// Ports: clk, rst (async, active-high), bus (cakegame_seq_recorder_if.slave: start/stop/buttons in,
// wr_en/wr_addr/wr_data RAM write port, length/recording/done/timeout/error status out).
// Build option: CAKEGAME_DEBOUNCE_EN enables button debouncing of DEBOUNCE cycles.
module cakegame_seq_recorder
  import cakegame_seq_recorder_pkg::*;
#(
  parameter int TIMEOUT = 5000,
  parameter int DEBOUNCE = 10
) (
  input logic clk,
  input logic rst,
  cakegame_seq_recorder_if.slave bus
);
  localparam int TW = $clog2(TIMEOUT);
  state_t state, state_n;
  logic [WIDTH-1:0] btn, play;
  logic [TW-1:0] timer;
  logic [ADDR_W:0] count;
  logic [ADDR_W-1:0] addr;
  logic discard, to_flag, err, tmo, press, start_ok;
  cakegame_seq_recorder_debouncer #(.DEBOUNCE(DEBOUNCE)) u_deb (.clk(clk), .rst(rst), .raw(bus.buttons), .stable(btn));
  assign start_ok = bus.start && (state == IDLE || state == DONE);
  assign tmo = timer == TW'(TIMEOUT - 1);
  assign press = state == WAIT_PRESS && state_n == WAIT_RELEASE;
  // stop beats timeout beats a press in the same cycle
  always_comb begin
    state_n = state;
    case (state)
      IDLE:         state_n = bus.start ? WAIT_PRESS : IDLE;
      WAIT_PRESS:   state_n = (bus.stop || tmo) ? DONE : (btn != '0) ? WAIT_RELEASE : WAIT_PRESS;
      WAIT_RELEASE: state_n = (btn != '0) ? WAIT_RELEASE : discard ? WAIT_PRESS : WRITE;
      WRITE:        state_n = (count == (ADDR_W+1)'(DEPTH - 1)) ? DONE : WAIT_PRESS;
      DONE:         state_n = bus.start ? WAIT_PRESS : DONE;
      default:      state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      timer <= '0;
      count <= '0;
      play <= '0;
      addr <= '0;
      discard <= 1'b0;
      to_flag <= 1'b0;
      err <= 1'b0;
    end else begin
      state <= state_n;
      timer <= (state == WAIT_PRESS) ? timer + TW'(1) : '0;
      err <= press && !one_hot(btn);
      if (press) discard <= !one_hot(btn);
      if (press && one_hot(btn)) play <= btn;
      if (start_ok) count <= '0;
      else if (state == WRITE) count <= count + (ADDR_W+1)'(1);
      // address is captured once on entry to WRITE so it stays put between writes
      if (state_n == WRITE) addr <= count[ADDR_W-1:0];
      if (start_ok) to_flag <= 1'b0;
      else if (state == WAIT_PRESS && !bus.stop && tmo) to_flag <= 1'b1;
    end
  end
  assign bus.wr_en = state == WRITE;
  assign bus.wr_addr = addr;
  assign bus.wr_data = play;
  assign bus.length = count;
  assign bus.recording = state == WAIT_PRESS || state == WAIT_RELEASE || state == WRITE;
  assign bus.done = state == DONE;
  assign bus.timeout = to_flag;
  assign bus.error = err;
endmodule

// File: tb/tb_cakegame_seq_recorder.sv
// tb_cakegame_seq_recorder: directed self-checking bench for the sequence recorder
module tb_cakegame_seq_recorder;
  import cakegame_seq_recorder_pkg::*;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int total = 0;
  int bad = 0;
  int wr_cnt = 0;
  int base = 0;
  int n = 0;
  logic [ADDR_W-1:0] log_a[$];
  logic [WIDTH-1:0] log_d[$];
  cakegame_seq_recorder_if bus();
  cakegame_seq_recorder dut (.clk(clk), .rst(rst), .bus(bus));
  always #5 clk = ~clk;
  always begin
    @(posedge clk);
    #2;
    if (bus.wr_en) begin
      wr_cnt++;
      log_a.push_back(bus.wr_addr);
      log_d.push_back(bus.wr_data);
    end
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, got, exp);
    end
  endtask
  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask
  task automatic pulse_start();
    bus.start = 1'b1;
    tick(1);
    bus.start = 1'b0;
  endtask
  task automatic pulse_stop();
    bus.stop = 1'b1;
    tick(1);
    bus.stop = 1'b0;
    tick(1);
  endtask
  task automatic play(input logic [WIDTH-1:0] b, input int hold);
    bus.buttons = b;
    tick(hold);
    bus.buttons = '0;
    tick(3);
  endtask
  function automatic logic [31:0] outs();
    return 32'({bus.wr_en, bus.wr_addr, bus.wr_data, bus.length, bus.recording, bus.done, bus.timeout, bus.error});
  endfunction
  initial begin
    bus.start = 1'b0;
    bus.stop = 1'b0;
    bus.buttons = '0;
    tick(2);
    chk("rst_outs", outs(), 0);
    rst = 1'b0;
    tick(2);
    chk("idle_outs", outs(), 0);
    // T1: single play then stop
    pulse_start();
    chk("t1_rec", bus.recording, 1);
    bus.buttons = 7'b0000100;
    tick(3);
    chk("t1_hold_nowr", bus.wr_en, 0);
    bus.buttons = '0;
    tick(1);
    chk("t1_lat", bus.wr_en, 1);
    chk("t1_addr", bus.wr_addr, 0);
    chk("t1_data", bus.wr_data, 7'b0000100);
    chk("t1_len_pre", bus.length, 0);
    tick(1);
    chk("t1_wr_drop", bus.wr_en, 0);
    chk("t1_len", bus.length, 1);
    pulse_stop();
    chk("t1_done", bus.done, 1);
    chk("t1_to", bus.timeout, 0);
    chk("t1_rec_off", bus.recording, 0);
    chk("t1_wrs", wr_cnt, 1);
    // T2: fill all 16 entries
    base = wr_cnt;
    log_a.delete();
    log_d.delete();
    pulse_start();
    chk("t2_len0", bus.length, 0);
    chk("t2_done0", bus.done, 0);
    for (int i = 0; i < 16; i++) play(7'(1 << (i % 7)), 2);
    chk("t2_wrs", wr_cnt - base, 16);
    for (int i = 0; i < 16 && i < log_a.size(); i++) begin
      chk($sformatf("t2_addr%0d", i), log_a[i], i);
      chk($sformatf("t2_data%0d", i), log_d[i], 1 << (i % 7));
    end
    chk("t2_done", bus.done, 1);
    chk("t2_len", bus.length, 16);
    play(7'b0000001, 2);
    chk("t2_no17", wr_cnt - base, 16);
    chk("t2_len_hold", bus.length, 16);
    // T3: multi-button press discarded, then a valid one
    base = wr_cnt;
    log_a.delete();
    log_d.delete();
    pulse_start();
    bus.buttons = 7'b0000011;
    tick(1);
    chk("t3_err", bus.error, 1);
    tick(1);
    chk("t3_err_1cyc", bus.error, 0);
    bus.buttons = '0;
    tick(3);
    chk("t3_nowr", wr_cnt - base, 0);
    chk("t3_rec", bus.recording, 1);
    play(7'b1000000, 2);
    chk("t3_wrs", wr_cnt - base, 1);
    if (log_a.size() > 0) begin
      chk("t3_addr", log_a[0], 0);
      chk("t3_data", log_d[0], 7'b1000000);
    end
    chk("t3_len", bus.length, 1);
    pulse_stop();
    chk("t3_done", bus.done, 1);
    // T5: stop wins over simultaneous press
    base = wr_cnt;
    pulse_start();
    bus.stop = 1'b1;
    bus.buttons = 7'b0010000;
    tick(1);
    bus.stop = 1'b0;
    bus.buttons = '0;
    tick(3);
    chk("t5_done", bus.done, 1);
    chk("t5_nowr", wr_cnt - base, 0);
    chk("t5_len", bus.length, 0);
    chk("t5_to", bus.timeout, 0);
    // T4: idle timeout after exactly TIMEOUT cycles
    base = wr_cnt;
    pulse_start();
    n = 0;
    while (!bus.done && n < 5100) begin
      tick(1);
      n++;
    end
    chk("t4_cycles", n, 5000);
    chk("t4_to", bus.timeout, 1);
    chk("t4_len", bus.length, 0);
    chk("t4_nowr", wr_cnt - base, 0);
    chk("t4_rec", bus.recording, 0);
    // T6: async reset in WAIT_RELEASE
    pulse_start();
    chk("t6_to_clr", bus.timeout, 0);
    bus.buttons = 7'b0000001;
    tick(2);
    chk("t6_rec", bus.recording, 1);
    base = wr_cnt;
    #2 rst = 1'b1;
    #1 chk("t6_async", outs(), 0);
    bus.buttons = '0;
    @(negedge clk);
    tick(3);
    rst = 1'b0;
    tick(4);
    chk("t6_nowr", wr_cnt - base, 0);
    chk("t6_idle", outs(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
